mvm_sequencer: RTL

Multi-cycle sequencer for the matrix-vector-multiply accelerator behind the CPU's `MVM`/`DIC` instructions. The controller's `ACC` strobe starts it. It then:
- streams an N-element vector and an N×N matrix out of data memory,
- drives a signed multiply-accumulate,
- stores N results in a local result buffer.

While it runs it stalls the CPU. `DIC` write-back reads the result buffer through `res_idx`/`res_data` (the `Mem_src` = 110 path).

---
 rtl/acc_pkg.sv | 24 ++
 rtl/mac_unit.sv | 50 +++++
 rtl/mvm_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the matrix-vector-multiply accelerator.
//   state_t      : sequencer FSM encoding (IDLE / LDV / MAC / DRAIN)
//   N/DW/AW_DEF  : default dimension, data width and address width
//   OP_MVM/DIC   : opcodes shared with the CPU controller
// ---------------------------------------------------------------------------
package acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LDV   = 2'd1,
        ST_MAC   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;

    localparam logic [4:0] OP_MVM = 5'b11111;
    localparam logic [4:0] OP_DIC = 5'b11110;

endpackage

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
// Signed DW x DW multiply feeding a 2*DW accumulator.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr_acc    : load the product instead of adding it (first term of a row)
//   i_en         : update the accumulator this cycle
//   i_a, i_b     : signed operands
//   o_acc        : registered accumulator
//   o_sum_lo     : low DW bits of the value the accumulator takes this edge,
//                  so a row result can be stored on the same edge it completes
// ---------------------------------------------------------------------------
module mac_unit #(
    parameter int DW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr_acc,
    input  logic              i_en,
    input  logic [DW-1:0]     i_a,
    input  logic [DW-1:0]     i_b,
    output logic [2*DW-1:0]   o_acc,
    output logic [DW-1:0]     o_sum_lo
);

    logic [2*DW-1:0] r_acc;
    logic [2*DW-1:0] w_a_ext;
    logic [2*DW-1:0] w_b_ext;
    logic [2*DW-1:0] w_prod;
    logic [2*DW-1:0] w_acc_nxt;

    // Sign-extend to 2*DW; the low 2*DW bits of the unsigned product of the
    // extended operands equal the signed DW x DW product.
    assign w_a_ext   = {{DW{i_a[DW-1]}}, i_a};
    assign w_b_ext   = {{DW{i_b[DW-1]}}, i_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_acc_nxt = i_clr_acc ? w_prod : (r_acc + w_prod);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc    = r_acc;
    assign o_sum_lo = w_acc_nxt[DW-1:0];

endmodule

// File: rtl/mvm_sequencer.sv
// ---------------------------------------------------------------------------
// mvm_sequencer
// Multi-cycle sequencer for the MVM instruction: loads an N-vector, streams
// an N x N row-major matrix, multiply-accumulates each row and stores N
// results that DIC write-back reads combinationally.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_acc_start            : start strobe, honoured only in IDLE
//   i_mat_base, i_vec_base : base addresses, sampled with i_acc_start
//   o_mem_rd, o_mem_addr   : data-memory read request / address
//   i_mem_rdata            : read data
//   o_busy                 : CPU stall, high in LDV, MAC and DRAIN
//   o_done                 : one-cycle pulse in the cycle after DRAIN
//   i_res_idx, o_res_data  : result-buffer read port
//   o_state, o_acc_dbg     : FSM state and accumulator, for observation
//
// Memory handshake: a request is o_mem_rd=1 with o_mem_addr in a cycle; the
// memory never stalls and returns i_mem_rdata exactly one cycle later. There
// is no ready; a registered valid/tag travels alongside each request so the
// returned word is steered to vbuf or the MAC without looking at the FSM.
// ---------------------------------------------------------------------------
module mvm_sequencer
    import acc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_acc_start,
    input  logic [AW-1:0]     i_mat_base,
    input  logic [AW-1:0]     i_vec_base,
    output logic              o_mem_rd,
    output logic [AW-1:0]     o_mem_addr,
    input  logic [DW-1:0]     i_mem_rdata,
    output logic              o_busy,
    output logic              o_done,
    input  logic [IW-1:0]     i_res_idx,
    output logic [DW-1:0]     o_res_data,
    output logic [1:0]        o_state,
    output logic [2*DW-1:0]   o_acc_dbg
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_mat_base;
    logic [AW-1:0]   r_vec_base;
    logic [IW-1:0]   r_k;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic            r_done;

    // Read pipeline: tag of the request issued last cycle.
    logic            r_rd_vld;
    logic            r_rd_mat;
    logic [IW-1:0]   r_rd_k;
    logic [IW-1:0]   r_rd_i;
    logic [IW-1:0]   r_rd_j;

    logic [DW-1:0]   r_vbuf [N];
    logic [DW-1:0]   r_res  [N];

    logic            w_mac_en;
    logic            w_mac_clr;
    logic [DW-1:0]   w_sum_lo;
    logic [2*DW-1:0] w_acc;

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_acc_start) w_state_nxt = ST_LDV;
            ST_LDV:   if (r_k == LAST) w_state_nxt = ST_MAC;
            ST_MAC:   if ((r_i == LAST) && (r_j == LAST)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- request outputs ----------------
    // N is a power of two, so i*N + j is simply {i, j}.
    always_comb begin
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        case (r_state)
            ST_LDV: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = r_vec_base + AW'(r_k);
            end
            ST_MAC: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = r_mat_base + AW'({r_i, r_j});
            end
            default: begin
                o_mem_rd   = 1'b0;
                o_mem_addr = '0;
            end
        endcase
    end

    // ---------------- state, counters, buffers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_mat_base <= '0;
            r_vec_base <= '0;
            r_k        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_done     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_mat   <= 1'b0;
            r_rd_k     <= '0;
            r_rd_i     <= '0;
            r_rd_j     <= '0;
            for (int n = 0; n < N; n++) begin
                r_vbuf[n] <= '0;
                r_res[n]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_DRAIN);

            case (r_state)
                ST_IDLE: begin
                    if (i_acc_start) begin
                        r_mat_base <= i_mat_base;
                        r_vec_base <= i_vec_base;
                        r_k        <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                    end
                end
                ST_LDV: r_k <= r_k + 1'b1;
                ST_MAC: begin
                    r_j <= r_j + 1'b1;
                    if (r_j == LAST) r_i <= r_i + 1'b1;
                end
                default: ;
            endcase

            r_rd_vld <= o_mem_rd;
            r_rd_mat <= (r_state == ST_MAC);
            r_rd_k   <= r_k;
            r_rd_i   <= r_i;
            r_rd_j   <= r_j;

            if (r_rd_vld && !r_rd_mat) begin
                r_vbuf[r_rd_k] <= i_mem_rdata;
            end
            // Last term of a row: keep the wrapped low DW bits.
            if (r_rd_vld && r_rd_mat && (r_rd_j == LAST)) begin
                r_res[r_rd_i] <= w_sum_lo;
            end
        end
    end

    // ---------------- MAC ----------------
    assign w_mac_en  = r_rd_vld && r_rd_mat;
    assign w_mac_clr = (r_rd_j == '0);

    mac_unit #(.DW(DW)) u_mac (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr_acc (w_mac_clr),
        .i_en      (w_mac_en),
        .i_a       (i_mem_rdata),
        .i_b       (r_vbuf[r_rd_j]),
        .o_acc     (w_acc),
        .o_sum_lo  (w_sum_lo)
    );

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_res_data = r_res[i_res_idx];
    assign o_state    = r_state;
    assign o_acc_dbg  = w_acc;

endmodule
